// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU output serialiser.
// Defining CPU_TX_PARITY_EN adds an even-parity bit to every frame.
package cpu_io_pkg;

  localparam int DATA_BITS = 8;

`ifdef CPU_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes when full
// and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observable once count > 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu_out_tx.sv
// Buffers CPU output bytes and sends each as an 8N1 serial frame on tx.
// Defining CPU_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module cpu_out_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_valid,
  input  logic [7:0] out_data,
  output logic       out_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       overflow
);
  import cpu_io_pkg::*;

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t            state;
  logic [15:0]          baud;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic [AW:0]          count;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
`ifdef CPU_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign out_ready = !full;
  assign push      = out_valid && out_ready;
  assign bit_end   = (baud == BAUD_LAST);
  assign tx_busy   = (state != IDLE) || (count != '0);
  // Pop exactly where the FSM loads a new frame: from IDLE, or at the end of STOP.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (out_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else if (out_valid && !out_ready) overflow <= 1'b1;
  end

  // Datapath: load on pop, shift right at the end of every data bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= head;
`ifdef CPU_TX_PARITY_EN
      par_bit <= even_parity(head);
`endif
    end else if ((state == DATA) && bit_end) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            baud  <= '0;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef CPU_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shift[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
`ifdef CPU_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 16'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (!empty) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_out_tx.sv
// Scoreboard bench for cpu_out_tx: a timeline model predicts acceptance and
// frame start edges; a monitor decodes tx frames and compares bit by bit.
module tb_cpu_out_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CPU_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FLEN = FRAME * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       out_valid = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       out_ready;
  logic       tx;
  logic       tx_busy;
  logic       overflow;

  cpu_out_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t expq[$];
  int     pend[$];
  int     cur_start = -100000;
  bit     exp_ovf = 1'b0;

  bit     mon_active = 1'b0;
  int     mon_pos = 0;
  bit     mon_bit_ok = 1'b1;
  frame_t mon_frame;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bit b of a frame: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (FRAME == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active && tx == 1'b0) begin
      if (expq.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        mon_frame = expq.pop_front();
        check($sformatf("start_edge_%02h", mon_frame.data), cyc - 1, mon_frame.start);
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_bit_ok = 1'b1;
      end
    end
    if (mon_active) begin
      if (tx !== exp_bit(mon_frame.data, mon_pos / CPB)) mon_bit_ok = 1'b0;
      if (mon_pos % CPB == CPB - 1) begin
        check($sformatf("frame_%02h_bit%0d", mon_frame.data, mon_pos / CPB), mon_bit_ok, 1);
        mon_bit_ok = 1'b1;
      end
      mon_pos++;
      if (mon_pos == FLEN) mon_active = 1'b0;
    end
  end

  // One cycle of stimulus; the model is advanced to the coming edge e.
  task automatic step(input bit v, input logic [7:0] d);
    int     e;
    int     last;
    int     s;
    bit     exp_ready;
    bit     exp_busy;
    frame_t f;
    @(negedge clk);
    out_valid = v;
    out_data  = d;
    e = cyc;
    while (pend.size() > 0 && pend[0] < e) cur_start = pend.pop_front();
    exp_ready = (pend.size() < DEPTH);
    exp_busy  = (pend.size() > 0) || (e - 1 < cur_start + FLEN);
    check("out_ready", out_ready, exp_ready);
    check("tx_busy", tx_busy, exp_busy);
    check("overflow", overflow, exp_ovf);
    if (v && exp_ready) begin
      last = (pend.size() > 0) ? pend[$] : cur_start;
      s = (e + 1 > last + FLEN) ? e + 1 : last + FLEN;
      pend.push_back(s);
      f.data  = d;
      f.start = s;
      expq.push_back(f);
    end
    if (v && !exp_ready) exp_ovf = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() > 0 || mon_active) && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("drain_in_time", (n < 3000), 1);
    repeat (3) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset     = 1'b0;
    out_valid = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_out_ready", out_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_overflow", overflow, 0);
    expq.delete();
    pend.delete();
    cur_start = -100000;
    exp_ovf   = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lows;
    #1 reset = 1'b0;
    #1;
    check("init_tx", tx, 1);
    check("init_out_ready", out_ready, 1);
    check("init_tx_busy", tx_busy, 0);
    check("init_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single frame.
    step(1'b1, 8'hA5);
    drain();

    // Three back-to-back frames.
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    drain();
    check("ovf_after_three", overflow, 0);

    // Burst of six: the sixth finds the FIFO full.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i));
    drain();
    check("ovf_after_burst", overflow, 1);

    // Reset during the data bits of a frame with two bytes queued.
    do_reset(2);
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    step(1'b1, 8'h5A);
    repeat (14) step(1'b0, 8'h00);
    do_reset(2);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00);
      if (tx == 1'b0) lows++;
    end
    check("quiet_after_reset", lows, 0);

    // Randomised traffic, fast enough to overflow now and then.
    step(1'b1, 8'h07);
    for (int i = 0; i < 250; i++) step(($urandom_range(0, 7) == 0), 8'($urandom));
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_out_tx.md
# cpu_out_tx

Output-side consumer for the CPU's 8-bit `cpu_out` result bus. It accepts bytes through a valid/ready handshake and buffers them in a small FIFO. It then transmits each byte as an asynchronous serial frame (start bit, 8 data bits LSB-first, stop bit) on a single `tx` line. It sits beside `cpu` at the top level, so program output can leave the chip without the bench sampling the parallel bus.

## Interface
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; legal range 2 to 65535.
- `FIFO_DEPTH`, 4, number of buffered bytes; must be a power of two, 2 or greater.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `out_valid`  in  1  a byte is presented on `out_data` this cycle.
- `out_data`  in  8  byte to transmit (the CPU's `cpu_out`).
- `out_ready`  out  1  FIFO not full; the byte is accepted on an edge where `out_valid && out_ready`.
- `tx`  out  1  serial line; idles high; registered.
- `tx_busy`  out  1  FSM is not in IDLE, or the FIFO is non-empty.
- `overflow`  out  1  sticky flag; set when `out_valid` is high while `out_ready` is low.

## Operation
- Reset values (immediate on `reset` low, no clock required):
  - `tx`=1, `out_ready`=1, `tx_busy`=0, `overflow`=0.
  - FIFO empty, FSM in IDLE, all counters 0.
- Push rule: `out_ready` = !full, computed from the registered count.
  - A push when full is dropped even if a pop happens on the same edge, and `overflow` is set.
  - `overflow` clears only on reset.
- Push and pop on the same edge when the FIFO is not full: count is unchanged and both actions take effect.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a shift register, clear the baud counter and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, then shift right. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter runs 0 to `CLKS_PER_BIT`-1 and wraps on every bit boundary. Bit index is 3 bits wide.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is log2(`FIFO_DEPTH`)+1 bits.
- Reset mid-frame: the frame aborts, `tx` returns high at once, buffered bytes are discarded, and there is no partial retransmission.

## Timing
- Push on edge N (FIFO was empty, FSM in IDLE):
  - Pop on edge N+1.
  - `tx` falls after edge N+1.
  - First data bit appears after edge N+1+`CLKS_PER_BIT`.
- Frame length is 10×`CLKS_PER_BIT` cycles (11× with parity).
- Back-to-back frames have no idle cycles between the stop bit and the next start bit.
- `tx_busy` falls on the edge where STOP exits to IDLE with the FIFO empty.

## Configuration
- `CPU_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - `tx` carries the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
- Undefined: no PARITY state, and the frame is 10 bits.

## Structure
- Package `cpu_io_pkg` holds:
  - the `tx_state_t` enum;
  - `DATA_BITS`=8;
  - `FRAME_BITS` (10, or 11 with parity, chosen by the macro).
- Sub-module `sync_fifo`, parameterised on width and depth. It has push/pop/full/empty/count ports and uses the same clock and active-low asynchronous reset.
- Top `cpu_out_tx` contains the FSM, baud counter, shift register and overflow flag.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset held low for 2 cycles -> `tx`=1, `out_ready`=1, `tx_busy`=0, `overflow`=0. Outputs are already in these states before the first clock edge.
- Push 0xA5 on edge 0 -> `tx` is 0 for cycles 1–4, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. `tx_busy` falls at edge 41.
- Push 0x01, 0x02, 0x03 on consecutive edges -> three contiguous frames with no high gap between them, 120 cycles total. `overflow` stays 0.
- Push 0x10..0x15 on 6 consecutive edges -> `out_ready` is low after edge 4. 0x15 is dropped and `overflow`=1. Only 0x10..0x14 appear on `tx`, in order.
- Pull reset low during DATA of the 0xA5 frame, with 2 bytes queued -> `tx`=1 at once, FIFO empty. After release, no further frames are sent.
- With `CPU_TX_PARITY_EN`, push 0x07 -> parity bit = 1 between data and stop. Frame is 44 cycles.
